bridge_buffer: RTL

Receiving end of the unbuffered connect router's bridge path. It captures each productive flit the router pushes (`push` + `eject`) into a small FIFO and signals `bfull` back to the router. It re-offers the stored flits, oldest first, as an injection request (`inj`) to the router on the adjacent ring, popping one on each `accept`. It sits between two rings in the hierarchical-ring fabric, one instance per bridge direction.

---
 rtl/bridge_buffer_pkg.sv | 12 +
 rtl/bridge_buffer_fifo_mem.sv | 26 ++
 rtl/bridge_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/bridge_buffer_pkg.sv
// Shared flit layout and types for the bridge buffer.
// Flit: [15] valid, [14:12] dest, [11:0] payload.
package bridge_buffer_pkg;

  localparam int CONTROL_W = 16;
  localparam int VALID_F   = 15;
  localparam int DEST_HI   = 14;
  localparam int DEST_LO   = 12;

  typedef logic [CONTROL_W-1:0] flit_t;

endpackage

// File: rtl/bridge_buffer_fifo_mem.sv
// Flit storage for the bridge buffer.
// One synchronous write port, one asynchronous read port.
import bridge_buffer_pkg::*;

module bridge_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  flit_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output flit_t         o_rdata
);

  flit_t r_mem [DEPTH];

  // Store the flit at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bridge_buffer.sv
// Bridge-path receive FIFO between two rings.
// Optional macro BRIDGE_BYPASS_EN: empty-FIFO cut-through to inj.
import bridge_buffer_pkg::*;

module bridge_buffer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  flit_t      eject,
  output logic       bfull,
  output flit_t      inj,
  input  logic       accept,
  output logic [2:0] bsize
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [2:0]    r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_we;
  logic          w_pop;
  logic [AW-1:0] w_wr_nxt;
  logic [AW-1:0] w_rd_nxt;
  flit_t         w_head;
  flit_t         w_stored;

  // Full/empty come from registered count only.
  assign w_full    = (r_count == FULL);
  assign w_empty   = (r_count == 3'd0);
  assign w_push_ok = push && eject[VALID_F] && !w_full;
  assign w_pop     = accept && !w_empty;

  assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;

  assign w_stored = w_empty ? '0 : w_head;

`ifdef BRIDGE_BYPASS_EN
  logic w_byp;

  // A valid push into an empty FIFO is offered at once;
  // if it is taken the same cycle it is never stored.
  assign w_byp = w_empty && push && eject[VALID_F];
  assign w_we  = w_push_ok && !(w_byp && accept);
  assign inj   = w_byp ? eject : w_stored;
`else
  assign w_we  = w_push_ok;
  assign inj   = w_stored;
`endif

  assign bfull = w_full;
  assign bsize = r_count;

  // Pointer and occupancy update; pointers wrap at DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_we)  r_wr_ptr <= w_wr_nxt;
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      unique case ({w_we, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  bridge_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (eject),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

endmodule
